// File: rtl/axi4_lite_slave_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_mem_pkg
// Brief    : Shared AXI4-Lite types: response codes, FSM states, config.
// Revision : 1.0 - initial release
// ============================================================================
package axi4_lite_slave_mem_pkg;

    // Upper bound on DELAY_WIDTH so the config struct has a fixed layout.
    localparam int c_max_delay_width = 16;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_WAIT = 2'd1,
        W_RESP = 2'd2
    } wr_state_t;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_WAIT = 2'd1,
        R_DATA = 2'd2
    } rd_state_t;

    typedef struct packed {
        logic [c_max_delay_width-1:0] write_delay;
        logic [c_max_delay_width-1:0] read_delay;
        logic                         priv_only;
    } cfg_t;

    function automatic resp_t resp_decode(input logic out_of_range,
                                          input logic priv_only,
                                          input logic prot_priv);
        if (out_of_range)
            return RESP_DECERR;
        else if (priv_only && !prot_priv)
            return RESP_SLVERR;
        else
            return RESP_OKAY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axi4_lite_slave_mem_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_mem_if
// Brief    : AXI4-Lite bus bundle with master and slave views.
// Revision : 1.0 - initial release
// ============================================================================
interface axi4_lite_slave_mem_if
    import axi4_lite_slave_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32
) ();
    logic [ADDRESS_WIDTH-1:0]  awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    resp_t                     bresp;
    logic                      bvalid;
    logic                      bready;
    logic [ADDRESS_WIDTH-1:0]  araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    resp_t                     rresp;
    logic                      rvalid;
    logic                      rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_slave_mem_delay_counter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_delay_counter
// Brief    : Loadable down-counter that saturates at zero.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_delay_counter #(
    parameter int WIDTH = 4
) (
    input  wire             clk,
    input  wire             rst,
    input  wire             i_load,
    input  wire [WIDTH-1:0] i_load_value,
    input  wire             i_dec,
    output wire             o_zero
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst)
            r_count <= '0;
        else if (i_load)
            r_count <= i_load_value;
        else if (i_dec && (r_count != '0))
            r_count <= r_count - 1'b1;
    end

    assign o_zero = (r_count == '0);
endmodule
`default_nettype wire

// File: rtl/axi4_lite_slave_mem.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_slave_mem
// Brief    : AXI4-Lite slave memory with ready delays, strobes, SLVERR/DECERR.
// Revision : 1.0 - initial release
// ============================================================================
module axi4_lite_slave_mem
    import axi4_lite_slave_mem_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH         = 16,
    parameter int DELAY_WIDTH   = 4
) (
    input  wire                   aclk,
    input  wire                   areset,
    input  wire [DELAY_WIDTH-1:0] cfg_write_delay,
    input  wire [DELAY_WIDTH-1:0] cfg_read_delay,
    input  wire                   cfg_priv_only,
    axi4_lite_slave_mem_if.slave  s_axi
);
    localparam int c_strb_w   = DATA_WIDTH / 8;
    localparam int c_addr_lsb = $clog2(c_strb_w);
    localparam int c_idx_w    = $clog2(DEPTH);
    localparam int c_idx_top  = c_addr_lsb + c_idx_w;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    cfg_t                  w_cfg;

    assign w_cfg.write_delay = c_max_delay_width'(cfg_write_delay);
    assign w_cfg.read_delay  = c_max_delay_width'(cfg_read_delay);
    assign w_cfg.priv_only   = cfg_priv_only;

    // Word-offset bits and the unused prot bits carry no meaning here.
    logic w_unused_bits;
    assign w_unused_bits = ^{s_axi.awaddr[c_addr_lsb-1:0], s_axi.araddr[c_addr_lsb-1:0],
                             s_axi.awprot[2:1], s_axi.arprot[2:1]};

    // ---------------- write channel ----------------
    wr_state_t            r_wr_state, w_wr_state_nxt;
    logic                 r_awready, w_awready_nxt;
    logic                 r_bvalid, w_bvalid_nxt;
    resp_t                r_bresp, w_bresp_nxt;
    logic                 r_wr_priv, w_wr_priv_nxt;
    logic                 w_wr_load, w_wr_dec, w_wr_zero, w_wr_commit, w_wr_both;
    logic [c_idx_w-1:0]   w_wr_idx;
    logic                 w_wr_oor;
    resp_t                w_wr_resp;

    assign w_wr_both = s_axi.awvalid && s_axi.wvalid;
    assign w_wr_idx  = s_axi.awaddr[c_idx_top-1:c_addr_lsb];
    assign w_wr_oor  = |s_axi.awaddr[ADDRESS_WIDTH-1:c_idx_top];
    assign w_wr_resp = resp_decode(w_wr_oor, r_wr_priv, s_axi.awprot[0]);

    axi4_lite_delay_counter #(.WIDTH(DELAY_WIDTH)) u_wr_cnt (
        .clk          (aclk),
        .rst          (areset),
        .i_load       (w_wr_load),
        .i_load_value (DELAY_WIDTH'(w_cfg.write_delay)),
        .i_dec        (w_wr_dec),
        .o_zero       (w_wr_zero)
    );

    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_awready_nxt  = 1'b0;
        w_bvalid_nxt   = r_bvalid;
        w_bresp_nxt    = r_bresp;
        w_wr_priv_nxt  = r_wr_priv;
        w_wr_load      = 1'b0;
        w_wr_dec       = 1'b0;
        w_wr_commit    = 1'b0;
        case (r_wr_state)
            W_IDLE: begin
                if (w_wr_both) begin
                    w_wr_load      = 1'b1;
                    w_wr_priv_nxt  = w_cfg.priv_only;
                    w_wr_state_nxt = W_WAIT;
                end
            end
            W_WAIT: begin
                if (!w_wr_both) begin
                    w_wr_state_nxt = W_IDLE;
                end else if (r_awready) begin
                    w_bresp_nxt    = w_wr_resp;
                    w_bvalid_nxt   = 1'b1;
                    w_wr_commit    = (w_wr_resp == RESP_OKAY);
                    w_wr_state_nxt = W_RESP;
                end else if (w_wr_zero) begin
                    // Ready is registered, so it appears one cycle after zero.
                    w_awready_nxt = 1'b1;
                end else begin
                    w_wr_dec = 1'b1;
                end
            end
            W_RESP: begin
                if (s_axi.bready) begin
                    w_bvalid_nxt   = 1'b0;
                    w_wr_state_nxt = W_IDLE;
                end
            end
            default: w_wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_wr_state <= W_IDLE;
            r_awready  <= 1'b0;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_priv  <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_awready  <= w_awready_nxt;
            r_bvalid   <= w_bvalid_nxt;
            r_bresp    <= w_bresp_nxt;
            r_wr_priv  <= w_wr_priv_nxt;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
        end else if (w_wr_commit) begin
            for (int b = 0; b < c_strb_w; b++)
                if (s_axi.wstrb[b])
                    r_mem[w_wr_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
        end
    end

    assign s_axi.awready = r_awready;
    assign s_axi.wready  = r_awready;
    assign s_axi.bvalid  = r_bvalid;
    assign s_axi.bresp   = r_bresp;

    // ---------------- read channel ----------------
    rd_state_t             r_rd_state, w_rd_state_nxt;
    logic                  r_arready, w_arready_nxt;
    logic                  r_rvalid, w_rvalid_nxt;
    resp_t                 r_rresp, w_rresp_nxt;
    logic [DATA_WIDTH-1:0] r_rdata, w_rdata_nxt;
    logic                  r_rd_priv, w_rd_priv_nxt;
    logic                  w_rd_load, w_rd_dec, w_rd_zero;
    logic [c_idx_w-1:0]    w_rd_idx;
    logic                  w_rd_oor;
    resp_t                 w_rd_resp;

    assign w_rd_idx  = s_axi.araddr[c_idx_top-1:c_addr_lsb];
    assign w_rd_oor  = |s_axi.araddr[ADDRESS_WIDTH-1:c_idx_top];
    assign w_rd_resp = resp_decode(w_rd_oor, r_rd_priv, s_axi.arprot[0]);

    axi4_lite_delay_counter #(.WIDTH(DELAY_WIDTH)) u_rd_cnt (
        .clk          (aclk),
        .rst          (areset),
        .i_load       (w_rd_load),
        .i_load_value (DELAY_WIDTH'(w_cfg.read_delay)),
        .i_dec        (w_rd_dec),
        .o_zero       (w_rd_zero)
    );

    always_comb begin
        w_rd_state_nxt = r_rd_state;
        w_arready_nxt  = 1'b0;
        w_rvalid_nxt   = r_rvalid;
        w_rresp_nxt    = r_rresp;
        w_rdata_nxt    = r_rdata;
        w_rd_priv_nxt  = r_rd_priv;
        w_rd_load      = 1'b0;
        w_rd_dec       = 1'b0;
        case (r_rd_state)
            R_IDLE: begin
                if (s_axi.arvalid) begin
                    w_rd_load      = 1'b1;
                    w_rd_priv_nxt  = w_cfg.priv_only;
                    w_rd_state_nxt = R_WAIT;
                end
            end
            R_WAIT: begin
                if (!s_axi.arvalid) begin
                    w_rd_state_nxt = R_IDLE;
                end else if (r_arready) begin
                    // Memory is sampled before any same-edge write lands.
                    w_rresp_nxt    = w_rd_resp;
                    w_rdata_nxt    = (w_rd_resp == RESP_OKAY) ? r_mem[w_rd_idx] : '0;
                    w_rvalid_nxt   = 1'b1;
                    w_rd_state_nxt = R_DATA;
                end else if (w_rd_zero) begin
                    w_arready_nxt = 1'b1;
                end else begin
                    w_rd_dec = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi.rready) begin
                    w_rvalid_nxt   = 1'b0;
                    w_rd_state_nxt = R_IDLE;
                end
            end
            default: w_rd_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_rd_state <= R_IDLE;
            r_arready  <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rresp    <= RESP_OKAY;
            r_rdata    <= '0;
            r_rd_priv  <= 1'b0;
        end else begin
            r_rd_state <= w_rd_state_nxt;
            r_arready  <= w_arready_nxt;
            r_rvalid   <= w_rvalid_nxt;
            r_rresp    <= w_rresp_nxt;
            r_rdata    <= w_rdata_nxt;
            r_rd_priv  <= w_rd_priv_nxt;
        end
    end

    assign s_axi.arready = r_arready;
    assign s_axi.rvalid  = r_rvalid;
    assign s_axi.rresp   = r_rresp;
    assign s_axi.rdata   = r_rdata;
endmodule
`default_nettype wire

// File: doc/axi4_lite_slave_mem.md
# axi4_lite_slave_mem

Synthesisable AXI4-Lite slave memory with a configurable ready delay on each address/data channel, byte-strobe writes, and error responses for protection and decode failures. It is the RTL-side counterpart of the verification agents. It acts as the DUT endpoint behind the slave interface, so master-agent sequences exercise real back-pressure and SLVERR/DECERR paths. Width, depth and delay range are parameters.

## Interface
- ADDRESS_WIDTH, 32: AXI address width.
- DATA_WIDTH, 32: data width; one of 32 or 64.
- DEPTH, 16: number of DATA_WIDTH words; power of two, at least 2.
- DELAY_WIDTH, 4: width of the ready-delay configuration fields.
- aclk  in  1  clock; all logic is on the rising edge.
- areset  in  1  reset, synchronous, active-high.
- cfg_write_delay  in  DELAY_WIDTH  cycles between both AW and W valid being seen and awready/wready.
- cfg_read_delay  in  DELAY_WIDTH  cycles between arvalid being seen and arready.
- cfg_priv_only  in  1  when 1, accesses with prot[0]=0 get SLVERR.
- awaddr/awprot/awvalid  in  ADDRESS_WIDTH/3/1; awready  out  1.
- wdata/wstrb/wvalid  in  DATA_WIDTH/DATA_WIDTH/8/1; wready  out  1.
- bresp  out  2; bvalid  out  1; bready  in  1.
- araddr/arprot/arvalid  in  ADDRESS_WIDTH/3/1; arready  out  1.
- rdata  out  DATA_WIDTH; rresp  out  2; rvalid  out  1; rready  in  1.

## Operation
- Word index = addr >> log2(DATA_WIDTH/8). Low address bits are ignored (no alignment error). An index of DEPTH or more decodes out of range.
- Response priority: DECERR (2'b11) for out of range, then SLVERR (2'b10) for the privilege violation, otherwise OKAY (2'b00). EXOKAY is never returned.
- Write FSM states:
  - W_IDLE: when awvalid && wvalid, load the counter with cfg_write_delay and go to W_WAIT.
  - W_WAIT: decrement the counter. When it is 0, drive awready=wready=1 for exactly one cycle, capture and respond, then go to W_RESP. If either valid drops while in W_WAIT (master protocol violation), return to W_IDLE with no handshake.
  - W_RESP: hold bvalid=1 and a stable bresp until bready, then go to W_IDLE.
- A write commits to memory only with an OKAY response. Each byte lane i is written only when wstrb[i]=1. wstrb=0 with OKAY leaves memory unchanged.
- Read FSM states mirror the write FSM: R_IDLE, R_WAIT (counter from cfg_read_delay), R_DATA.
  - arready is high for one cycle. rdata and rresp are captured at that handshake.
  - rvalid holds until rready.
  - On a non-OKAY response rdata is 0.
- The read and write FSMs are independent and may run concurrently.
- A read whose handshake coincides with a write commit to the same word returns the pre-write data.
- Config inputs are sampled only on the W_IDLE→W_WAIT and R_IDLE→R_WAIT transitions. Changes mid-transaction have no effect on it.

## Timing
- Reset (areset=1 at an edge): all ready and valid outputs go to 0, bresp=rresp=0, rdata=0, both FSMs go to IDLE, and every memory word goes to 0. A transaction pending at reset is dropped with no response.
- With the valids sampled high in IDLE at edge N, ready is high in the cycle after edge N+1+delay. Delay 0 therefore gives ready one cycle after valid.
- bvalid/rvalid rise the cycle after the handshake cycle. The minimum write round trip is 3 cycles from valid to bvalid with bready tied high.
- No new address is accepted on a channel until its B/R handshake completes, i.e. one outstanding transaction per direction.
- A delay of 2^DELAY_WIDTH-1 is legal. The counter does not wrap.

## Structure
- Extend the shared AXI4-Lite globals package with:
  - a response-code enum (OKAY/EXOKAY/SLVERR/DECERR),
  - write and read FSM state enums,
  - a config struct {write delay, read delay, priv_only}.
- Natural sub-module: axi4_lite_delay_counter (load, decrement, zero flag), instantiated once per direction.

## Test plan
- Delay 0, write addr 0x4 data 0xDEADBEEF strb 0xF, then read 0x4 → awready at cycle+1; bresp=00; rdata=0xDEADBEEF, rresp=00.
- cfg_write_delay=5, AW and W valid held → awready/wready high exactly 6 cycles after valid, for one cycle; bvalid held 4 cycles while bready=0, with bresp stable.
- Write 0x12345678 strb 0xF, then 0xAA strb 0x1, read back → 0x123456AA.
- Address 0x40 with DEPTH=16 and 32-bit data → bresp=11 with memory unchanged; read gives rresp=11, rdata=0.
- cfg_priv_only=1, awprot=3'b000 → bresp=10 with no commit; awprot=3'b001 → bresp=00 with commit.
- Same-cycle read and write handshake on word 2 (old value 0x1, new value 0x2) → rdata=0x1, and a later read gives 0x2. Reset asserted during R_WAIT → arready and rvalid stay 0 and memory reads 0 afterwards.
